// File: rtl/ysyx_22040729_ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time over a
// valid/ready memory interface and hands it to decode; supports redirects and squashing.
module ysyx_22040729_ifu #(
    parameter int unsigned          ADDR_W     = 64,
    parameter int unsigned          INST_W     = 32,
    parameter logic [ADDR_W-1:0]    RESET_ADDR = ADDR_W'(64'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INST_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic              id_misalign
);

    localparam logic [INST_W-1:0] NOP = INST_W'(32'h0000_0013);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_buf_q, inst_buf_d;
    logic [ADDR_W-1:0] pc_buf_q, pc_buf_d;
    logic              misalign_buf_q, misalign_buf_d;
    logic              drop_q, drop_d;
    logic              pc_aligned;

    assign pc_aligned = (pc_q[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            pc_q           <= RESET_ADDR;
            inst_buf_q     <= NOP;
            pc_buf_q       <= RESET_ADDR;
            misalign_buf_q <= 1'b0;
            drop_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            inst_buf_q     <= inst_buf_d;
            pc_buf_q       <= pc_buf_d;
            misalign_buf_q <= misalign_buf_d;
            drop_q         <= drop_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        inst_buf_d     = inst_buf_q;
        pc_buf_d       = pc_buf_q;
        misalign_buf_d = misalign_buf_q;
        drop_d         = drop_q;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
                if (redirect_valid) pc_d = redirect_pc;
            end
            StReq: begin
                if (pc_aligned) begin
                    if (imem_req_ready) begin
                        // Accepted with the old pc; a same-cycle redirect makes it stale.
                        state_d = StWait;
                        drop_d  = redirect_valid;
                    end
                    if (redirect_valid) pc_d = redirect_pc;
                end else if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else begin
                    inst_buf_d     = NOP;
                    pc_buf_d       = pc_q;
                    misalign_buf_d = 1'b1;
                    state_d        = StHold;
                end
            end
            StWait: begin
                if (imem_resp_valid) begin
                    drop_d = 1'b0;
                    if (redirect_valid) begin
                        pc_d    = redirect_pc;
                        state_d = StReq;
                    end else if (drop_q) begin
                        state_d = StReq;
                    end else begin
                        inst_buf_d     = imem_resp_data;
                        pc_buf_d       = pc_q;
                        misalign_buf_d = 1'b0;
                        state_d        = StHold;
                    end
                end else if (redirect_valid) begin
                    pc_d   = redirect_pc;
                    drop_d = 1'b1;
                end
            end
            StHold: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = StReq;
                end else if (id_ready) begin
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign imem_req_valid = (state_q == StReq) && pc_aligned;
    assign imem_req_addr  = pc_q;
    assign id_valid       = (state_q == StHold);
    assign id_inst        = inst_buf_q;
    assign id_pc          = pc_buf_q;
    assign id_misalign    = misalign_buf_q;

endmodule
